// File: rtl/uart_rx_checked.sv
// uart_rx_checked
// UART receiver: 8 data bits LSB first, optional parity, 1 stop bit.
// The serial line is synchronised, and each bit is decided by a 3-sample
// majority vote around mid-bit. Short low glitches on an idle line are
// rejected as false starts. Each completed frame produces a one-cycle
// valid pulse with the byte and the parity, framing and break flags.
//
// Parameters
//   CLKS_PER_BIT  clocks per bit period (>= 8)
//   PARITY        0 = none, 1 = odd, 2 = even
//
// Ports
//   i_Clock       system clock, rising edge
//   i_Rst_L       synchronous active-low reset
//   i_RX_Serial   asynchronous serial line, idle high
//   o_RX_DV       one-cycle pulse when a frame completes
//   o_RX_Byte     received byte, updated only with o_RX_DV
//   o_Parity_Err  parity mismatch, qualified by o_RX_DV
//   o_Frame_Err   stop bit sampled low, qualified by o_RX_DV
//   o_Break       framing error on an all-zero frame, qualified by o_RX_DV
//   o_RX_Active   high from start-bit detection until back in idle
module uart_rx_checked #(
  parameter int CLKS_PER_BIT = 217,
  parameter int PARITY       = 0
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_Parity_Err,
  output logic       o_Frame_Err,
  output logic       o_Break,
  output logic       o_RX_Active
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(HALF + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Odd parity expects an odd number of ones across data plus parity bit,
  // even parity an even number.
  function automatic logic parity_error(input logic [7:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    if (PARITY == 0) return 1'b0;
    return x != (PARITY == 1);
  endfunction

  // Control state
  logic             rx_meta_q, rx_s_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             dv_q, dv_d;
  logic [7:0]       byte_q, byte_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             brk_q, brk_d;

  // Datapath (no reset: every bit is written before it is consumed)
  logic             smp0_q, smp1_q;
  logic [7:0]       shreg_q;
  logic             par_bit_q;

  logic             vote;
  logic             at_vote;
  logic             bit_end;

  // The third sample is rx_s itself at count HALF+1, so the vote is
  // complete in that cycle and everything depending on it is registered
  // there; the decision becomes visible in the following cycle.
  assign vote    = maj3(smp0_q, smp1_q, rx_s_q);
  assign at_vote = (cnt_q == CNT_VOTE);
  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      dv_q      <= 1'b0;
      byte_q    <= 8'h00;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      rx_meta_q <= i_RX_Serial;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      dv_q      <= dv_d;
      byte_q    <= byte_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      brk_q     <= brk_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (cnt_q == CNT_S0) smp0_q <= rx_s_q;
    if (cnt_q == CNT_S1) smp1_q <= rx_s_q;
    if (at_vote && state_q == ST_DATA)   shreg_q[bit_idx_q] <= vote;
    if (at_vote && state_q == ST_PARITY) par_bit_q <= vote;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = bit_end ? '0 : cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    dv_d      = 1'b0;
    byte_d    = byte_q;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    brk_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s_q) state_d = ST_START;
      end

      ST_START: begin
        if (at_vote && vote) begin
          // Line came back high by mid-bit: treat as a glitch.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end

      ST_STOP: begin
        if (at_vote) begin
          dv_d   = 1'b1;
          byte_d = shreg_q;
          perr_d = parity_error(shreg_q, par_bit_q);
          ferr_d = !vote;
          brk_d  = !vote && (shreg_q == 8'h00) &&
                   ((PARITY == 0) || !par_bit_q);
          cnt_d  = '0;
          // Leaving mid-stop lets the next start edge be caught with no gap.
          state_d = vote ? ST_IDLE : ST_WAIT_HIGH;
        end
      end

      ST_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s_q) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_RX_DV      = dv_q;
  assign o_RX_Byte    = byte_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err  = ferr_q;
  assign o_Break      = brk_q;
  assign o_RX_Active  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_checked.sv
// Testbench for uart_rx_checked: one instance with default parameters and
// one with even parity and a short bit period. Received frames are logged
// by negedge monitors and compared against expectations computed from the
// bits that were put on the line.
module tb_uart_rx_checked;

  localparam int CPB_N = 217;
  localparam int CPB_P = 20;
  localparam int PAR_P = 2;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       rx_n, rx_p;

  logic       dv_n, pe_n, fe_n, br_n, act_n;
  logic [7:0] byte_n;
  logic       dv_p, pe_p, fe_p, br_p, act_p;
  logic [7:0] byte_p;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int drive_cyc;
  int start_cyc_n;
  int act_rises_n = 0;
  logic act_prev_n = 1'b0;

  typedef struct {
    logic [7:0] b;
    logic       pe;
    logic       fe;
    logic       br;
    logic       act;
    int         c;
  } ev_t;

  ev_t q_n[$];
  ev_t q_p[$];

  uart_rx_checked #(.CLKS_PER_BIT(CPB_N), .PARITY(0)) dut_n (
    .i_Clock(clk), .i_Rst_L(rst_l), .i_RX_Serial(rx_n),
    .o_RX_DV(dv_n), .o_RX_Byte(byte_n), .o_Parity_Err(pe_n),
    .o_Frame_Err(fe_n), .o_Break(br_n), .o_RX_Active(act_n)
  );

  uart_rx_checked #(.CLKS_PER_BIT(CPB_P), .PARITY(PAR_P)) dut_p (
    .i_Clock(clk), .i_Rst_L(rst_l), .i_RX_Serial(rx_p),
    .o_RX_DV(dv_p), .o_RX_Byte(byte_p), .o_Parity_Err(pe_p),
    .o_Frame_Err(fe_p), .o_Break(br_p), .o_RX_Active(act_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon_n
    ev_t e;
    if (dv_n) begin
      e.b = byte_n; e.pe = pe_n; e.fe = fe_n; e.br = br_n; e.act = act_n; e.c = cyc;
      q_n.push_back(e);
    end
    if (act_n && !act_prev_n) begin
      start_cyc_n <= cyc;
      act_rises_n <= act_rises_n + 1;
    end
    act_prev_n <= act_n;
  end

  always @(negedge clk) begin : mon_p
    ev_t e;
    if (dv_p) begin
      e.b = byte_p; e.pe = pe_p; e.fe = fe_p; e.br = br_p; e.act = act_p; e.c = cyc;
      q_p.push_back(e);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Invariant: every task starts and ends 1 time unit after a rising edge.
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_n = v;
    else rx_p = v;
  endtask

  // Start bit, data LSB first, optional parity bit, then the stop level
  // held for stop_len bit times. The line is left at the stop level.
  task automatic send_frame(input int sel, input logic [7:0] d, input bit use_par,
                            input bit pb, input bit stop, input int stop_len);
    int cpb;
    cpb = (sel == 0) ? CPB_N : CPB_P;
    set_line(sel, 1'b0);
    if (sel == 0) drive_cyc = cyc;
    hold(cpb);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      hold(cpb);
    end
    if (use_par) begin
      set_line(sel, pb);
      hold(cpb);
    end
    set_line(sel, stop);
    hold(cpb * stop_len);
  endtask

  // Reference rules: {parity_err, frame_err, break}
  function automatic logic [2:0] ref_flags(input logic [7:0] d, input int par_mode,
                                           input bit pb, input bit stop);
    int ones;
    logic pe, fe, br;
    ones = $countones(d) + ((par_mode != 0) ? int'(pb) : 0);
    if (par_mode == 1)      pe = (ones % 2) == 0;
    else if (par_mode == 2) pe = (ones % 2) == 1;
    else                    pe = 1'b0;
    fe = !stop;
    br = fe && (d == 8'h00) && (par_mode == 0 || !pb);
    return {pe, fe, br};
  endfunction

  task automatic check_frame(input int sel, input string tag, input logic [7:0] d,
                             input bit pb, input bit stop);
    ev_t e;
    int n;
    int pm;
    logic [2:0] f;
    pm = (sel == 0) ? 0 : PAR_P;
    n  = (sel == 0) ? q_n.size() : q_p.size();
    check({tag, "_dv_count"}, n, 1);
    if (n > 0) begin
      e = (sel == 0) ? q_n.pop_front() : q_p.pop_front();
      f = ref_flags(d, pm, pb, stop);
      check({tag, "_byte"}, e.b, d);
      check({tag, "_flags"}, {e.pe, e.fe, e.br}, f);
      check({tag, "_active_at_dv"}, e.act, !stop);
      if (sel == 0) check({tag, "_latency"}, e.c - start_cyc_n, 9 * CPB_N + CPB_N / 2 + 2);
    end
  endtask

  initial begin
    logic [7:0] d;
    bit pb, stp;
    int rises;

    rst_l = 1'b0;
    rx_n  = 1'b1;
    rx_p  = 1'b1;
    @(posedge clk);
    #1;
    hold(3);
    check("reset_outputs_n", {dv_n, byte_n, pe_n, fe_n, br_n, act_n}, 13'h0);
    check("reset_outputs_p", {dv_p, byte_p, pe_p, fe_p, br_p, act_p}, 13'h0);
    rst_l = 1'b1;
    hold(5);

    // Basic frames, no parity
    send_frame(0, 8'h37, 1'b0, 1'b0, 1'b1, 1);
    hold(10);
    check("start_detect_delay", start_cyc_n - drive_cyc, 3);
    check_frame(0, "f37", 8'h37, 1'b0, 1'b1);
    send_frame(0, 8'h2F, 1'b0, 1'b0, 1'b1, 1);
    hold(10);
    check_frame(0, "f2F", 8'h2F, 1'b0, 1'b1);
    check("byte_hold_2F", {dv_n, byte_n, pe_n, fe_n, br_n}, {1'b0, 8'h2F, 3'b000});

    // Even parity instance
    send_frame(1, 8'hA5, 1'b1, 1'b0, 1'b1, 1);
    hold(2 * CPB_P);
    check_frame(1, "pA5_ok", 8'hA5, 1'b0, 1'b1);
    send_frame(1, 8'hA5, 1'b1, 1'b1, 1'b1, 1);
    hold(2 * CPB_P);
    check_frame(1, "pA5_bad", 8'hA5, 1'b1, 1'b1);
    send_frame(1, 8'h00, 1'b1, 1'b0, 1'b0, 1);
    set_line(1, 1'b1);
    hold(2 * CPB_P);
    check_frame(1, "p00_break", 8'h00, 1'b0, 1'b0);
    send_frame(1, 8'h00, 1'b1, 1'b1, 1'b0, 1);
    set_line(1, 1'b1);
    hold(2 * CPB_P);
    check_frame(1, "p00_par1", 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      d   = 8'($urandom_range(0, 255));
      pb  = 1'($urandom_range(0, 1));
      stp = ($urandom_range(0, 3) != 0);
      send_frame(1, d, 1'b1, pb, stp, 1);
      set_line(1, 1'b1);
      hold(2 * CPB_P);
      check_frame(1, $sformatf("prand%0d", i), d, pb, stp);
    end

    // Stop bit low, line recovers after two bit times
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 2);
    check("fe_active_held", act_n, 1'b1);
    check("fe_flags_cleared", {dv_n, byte_n, pe_n, fe_n, br_n}, {1'b0, 8'h55, 3'b000});
    set_line(0, 1'b1);
    hold(4);
    check("fe_active_released", act_n, 1'b0);
    check_frame(0, "f55_ferr", 8'h55, 1'b0, 1'b0);
    hold(CPB_N);
    send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, 1);
    hold(10);
    check_frame(0, "f12_after_fe", 8'h12, 1'b0, 1'b1);

    // Line held low for 12 bit times
    set_line(0, 1'b0);
    hold(12 * CPB_N);
    check("break_active_low", act_n, 1'b1);
    set_line(0, 1'b1);
    hold(3 * CPB_N);
    check("break_active_end", act_n, 1'b0);
    check_frame(0, "break", 8'h00, 1'b0, 1'b0);

    // Short glitch on idle line
    rises = act_rises_n;
    set_line(0, 1'b0);
    hold(20);
    set_line(0, 1'b1);
    hold(3 * CPB_N);
    check("glitch_active_pulsed", act_rises_n - rises, 1);
    check("glitch_no_dv", q_n.size(), 0);
    check("glitch_idle", act_n, 1'b0);
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1, 1);
    hold(10);
    check_frame(0, "fC3", 8'hC3, 1'b0, 1'b1);

    // Back-to-back frames
    send_frame(0, 8'h01, 1'b0, 1'b0, 1'b1, 1);
    send_frame(0, 8'hFE, 1'b0, 1'b0, 1'b1, 1);
    send_frame(0, 8'h80, 1'b0, 1'b0, 1'b1, 1);
    hold(10);
    check("b2b_count", q_n.size(), 3);
    if (q_n.size() == 3) begin
      check("b2b_byte0", q_n[0].b, 8'h01);
      check("b2b_byte1", q_n[1].b, 8'hFE);
      check("b2b_byte2", q_n[2].b, 8'h80);
      check("b2b_flags", {q_n[0].fe, q_n[1].fe, q_n[2].fe, q_n[0].pe, q_n[1].pe, q_n[2].pe}, 6'h0);
    end
    q_n.delete();

    // Reset in the middle of the second of two frames
    send_frame(0, 8'h01, 1'b0, 1'b0, 1'b1, 1);
    set_line(0, 1'b0);
    hold(CPB_N);
    for (int i = 0; i < 4; i++) begin
      set_line(0, (i == 0) ? 1'b0 : 1'b1);
      hold(CPB_N);
    end
    set_line(0, 1'b1);
    hold(CPB_N / 2);
    check("pre_reset_byte", byte_n, 8'h01);
    rst_l = 1'b0;
    hold(1);
    check("midframe_reset_outputs", {dv_n, byte_n, pe_n, fe_n, br_n, act_n}, 13'h0);
    rst_l = 1'b1;
    hold(12 * CPB_N);
    check("midframe_reset_dv_count", q_n.size(), 1);
    if (q_n.size() > 0) check("midframe_first_byte", q_n[0].b, 8'h01);
    check("midframe_reset_idle", act_n, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
